// File: rtl/bus_arbiter_pkg.sv
// Shared encodings for the core memory-bus arbiter: FSM states, grant codes
// and the default transaction timeout.
package bus_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam logic [1:0] GNT_JTAG = 2'd0;
    localparam logic [1:0] GNT_EX   = 2'd1;
    localparam logic [1:0] GNT_IF   = 2'd2;
    localparam logic [1:0] GNT_NONE = 2'd3;

    localparam int TIMEOUT_CYC_DEF = 16;

endpackage

// File: rtl/arb_prio_enc.sv
// Fixed-priority encoder for the three bus masters: req[0] (JTAG) wins over
// req[1] (EX) which wins over req[2] (IF); GNT_NONE when nobody requests.
module arb_prio_enc
    import bus_arbiter_pkg::*;
(
    input  logic [2:0] req,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = GNT_NONE;
        if (req[0]) begin
            gnt = GNT_JTAG;
        end else if (req[1]) begin
            gnt = GNT_EX;
        end else if (req[2]) begin
            gnt = GNT_IF;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Non-preemptive fixed-priority arbiter sharing one slave bus between JTAG,
// EX load/store and instruction fetch, with a per-transaction timeout.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,

    input  logic              m2_req,
    input  logic              m2_we,
    input  logic [ADDR_W-1:0] m2_addr,
    input  logic [DATA_W-1:0] m2_wdata,
    output logic              m2_ack,
    output logic [DATA_W-1:0] m2_rdata,
    output logic              m2_err,

    output logic              s_req,
    output logic              s_we,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic              s_ack,
    input  logic [DATA_W-1:0] s_rdata,

    output logic [1:0]        grant,
    output logic              fetch_hold
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_t       state, state_nxt;
    logic [1:0]       grant_q, grant_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;

    logic [2:0]        req_vec;
    logic [1:0]        pe_gnt;
    logic              sel_req;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              timeout;
    logic              done;
    logic              done_err;
    logic [DATA_W-1:0] done_rdata;

    assign req_vec = {m2_req, m1_req, m0_req};
    assign timeout = (cnt_q == CNT_LAST);

    arb_prio_enc u_prio (
        .req (req_vec),
        .gnt (pe_gnt)
    );

    // Request/data view of whichever master currently owns the bus.
    always_comb begin
        sel_req   = 1'b0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        case (grant_q)
            GNT_JTAG: begin
                sel_req   = m0_req;
                sel_we    = m0_we;
                sel_addr  = m0_addr;
                sel_wdata = m0_wdata;
            end
            GNT_EX: begin
                sel_req   = m1_req;
                sel_we    = m1_we;
                sel_addr  = m1_addr;
                sel_wdata = m1_wdata;
            end
            GNT_IF: begin
                sel_req   = m2_req;
                sel_we    = m2_we;
                sel_addr  = m2_addr;
                sel_wdata = m2_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARB_IDLE;
            grant_q <= GNT_NONE;
            cnt_q   <= '0;
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        cnt_nxt   = cnt_q;
        case (state)
            ARB_IDLE: begin
                if (|req_vec) begin
                    grant_nxt = pe_gnt;
                    cnt_nxt   = '0;
                    state_nxt = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                // A dropped request abandons the access without completion.
                if (!sel_req || s_ack || timeout) begin
                    state_nxt = ARB_IDLE;
                end else if (cnt_q != CNT_LAST) begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        grant      = GNT_NONE;
        s_req      = 1'b0;
        s_we       = 1'b0;
        s_addr     = '0;
        s_wdata    = '0;
        done       = 1'b0;
        done_err   = 1'b0;
        done_rdata = '0;
        if (state == ARB_BUSY) begin
            grant   = grant_q;
            s_req   = sel_req;
            s_we    = sel_we;
            s_addr  = sel_addr;
            s_wdata = sel_wdata;
            // Slave ack beats a coincident timeout; reset aborts silently.
            if (sel_req && !rst) begin
                if (s_ack) begin
                    done       = 1'b1;
                    done_rdata = s_rdata;
                end else if (timeout) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end
            end
        end
    end

    always_comb begin
        m0_ack   = done && (grant_q == GNT_JTAG);
        m1_ack   = done && (grant_q == GNT_EX);
        m2_ack   = done && (grant_q == GNT_IF);
        m0_err   = m0_ack && done_err;
        m1_err   = m1_ack && done_err;
        m2_err   = m2_ack && done_err;
        m0_rdata = m0_ack ? done_rdata : '0;
        m1_rdata = m1_ack ? done_rdata : '0;
        m2_rdata = m2_ack ? done_rdata : '0;
    end

    assign fetch_hold = m2_req & ~m2_ack;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: scoreboard of expected completions checked
// by a negedge monitor, plus per-cycle grant/bus checks from the main sequence.
module tb_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]    mreq;
    logic [2:0]    mwe;
    logic [AW-1:0] maddr  [3];
    logic [DW-1:0] mwdata [3];
    wire  [2:0]    mack;
    wire  [2:0]    merr;
    wire  [DW-1:0] mrdata [3];

    wire           s_req;
    wire           s_we;
    wire  [AW-1:0] s_addr;
    wire  [DW-1:0] s_wdata;
    logic          s_ack;
    logic [DW-1:0] s_rdata;
    wire  [1:0]    grant;
    wire           fetch_hold;

    bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .m0_req     (mreq[0]),
        .m0_we      (mwe[0]),
        .m0_addr    (maddr[0]),
        .m0_wdata   (mwdata[0]),
        .m0_ack     (mack[0]),
        .m0_rdata   (mrdata[0]),
        .m0_err     (merr[0]),
        .m1_req     (mreq[1]),
        .m1_we      (mwe[1]),
        .m1_addr    (maddr[1]),
        .m1_wdata   (mwdata[1]),
        .m1_ack     (mack[1]),
        .m1_rdata   (mrdata[1]),
        .m1_err     (merr[1]),
        .m2_req     (mreq[2]),
        .m2_we      (mwe[2]),
        .m2_addr    (maddr[2]),
        .m2_wdata   (mwdata[2]),
        .m2_ack     (mack[2]),
        .m2_rdata   (mrdata[2]),
        .m2_err     (merr[2]),
        .s_req      (s_req),
        .s_we       (s_we),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_ack      (s_ack),
        .s_rdata    (s_rdata),
        .grant      (grant),
        .fetch_hold (fetch_hold)
    );

    // Slave model: acks after slv_wait wait states; read data = key ^ address.
    logic          slv_en;
    logic          stray;
    int            slv_wait;
    int            scnt = 0;
    logic [DW-1:0] slv_key;

    always_comb s_ack   = (slv_en && s_req && (scnt == slv_wait)) || stray;
    always_comb s_rdata = slv_key ^ s_addr;
    always @(posedge clk) begin
        if (!s_req || s_ack) scnt <= 0;
        else                 scnt <= scnt + 1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            m;
        logic [DW-1:0] rdata;
        logic          err;
        int            cyc;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int x = 0; x < 3; x++) begin
            if (mack[x] === 1'b1) begin
                exp_t e;
                checks++;
                assert (sb.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_ack master %0d observed ack expected none", x);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("ack_master", 64'(x), 64'(e.m));
                    chk("ack_cycle", 64'(cyc), 64'(e.cyc));
                    chk("ack_rdata", 64'(mrdata[x]), 64'(e.rdata));
                    chk("ack_err", 64'(merr[x]), 64'(e.err));
                end
            end else begin
                chk("nonack_outputs", 64'({merr[x], mrdata[x]}), 64'd0);
            end
        end
    end

    task automatic half();
        @(negedge clk);
    endtask

    // Advance to just after the next edge, releasing any master acked this cycle.
    task automatic adv();
        logic [2:0] a;
        a = mack;
        @(posedge clk);
        #1;
        for (int x = 0; x < 3; x++) if (a[x]) mreq[x] = 1'b0;
    endtask

    initial begin
        logic [1:0] g_exp2 [7];
        logic       fh_exp [7];
        logic [1:0] g_exp3 [10];

        rst      = 1'b1;
        mreq     = 3'b100;
        mwe      = 3'b000;
        for (int x = 0; x < 3; x++) begin
            maddr[x]  = '0;
            mwdata[x] = '0;
        end
        slv_en   = 1'b1;
        stray    = 1'b0;
        slv_wait = 0;
        slv_key  = '0;

        // Reset state (m2_req held high to observe fetch_hold passthrough)
        repeat (2) @(posedge clk);
        #1;
        half();
        chk("rst_grant", 64'(grant), 64'd3);
        chk("rst_s_req", 64'(s_req), 64'd0);
        chk("rst_s_we", 64'(s_we), 64'd0);
        chk("rst_s_addr", 64'(s_addr), 64'd0);
        chk("rst_s_wdata", 64'(s_wdata), 64'd0);
        chk("rst_acks", 64'({mack, merr}), 64'd0);
        chk("rst_fetch_hold", 64'(fetch_hold), 64'd1);
        adv();
        mreq = 3'b000;
        rst  = 1'b0;
        half();
        chk("idle_fetch_hold", 64'(fetch_hold), 64'd0);
        chk("idle_grant", 64'(grant), 64'd3);
        adv();

        // m2 read alone, zero-wait slave
        maddr[2] = 32'h0000_0100;
        mwe[2]   = 1'b0;
        slv_key  = 32'hDEAD_BEEF ^ 32'h0000_0100;
        mreq[2]  = 1'b1;
        sb.push_back('{2, 32'hDEAD_BEEF, 1'b0, cyc + 1});
        half();
        chk("t1_c0_s_req", 64'(s_req), 64'd0);
        chk("t1_c0_grant", 64'(grant), 64'd3);
        chk("t1_c0_fetch_hold", 64'(fetch_hold), 64'd1);
        adv();
        half();
        chk("t1_c1_s_req", 64'(s_req), 64'd1);
        chk("t1_c1_grant", 64'(grant), 64'd2);
        chk("t1_c1_s_addr", 64'(s_addr), 64'h100);
        chk("t1_c1_s_we", 64'(s_we), 64'd0);
        chk("t1_c1_acks", 64'(mack), 64'b100);
        chk("t1_c1_fetch_hold", 64'(fetch_hold), 64'd0);
        adv();
        half();
        chk("t1_c2_grant", 64'(grant), 64'd3);
        chk("t1_c2_s_req", 64'(s_req), 64'd0);
        adv();

        // All three masters request together
        maddr[0]  = 32'h0000_1000;
        maddr[1]  = 32'h0000_2000;
        maddr[2]  = 32'h0000_3000;
        mwe       = 3'b010;
        mwdata[1] = 32'h1111_2222;
        slv_key   = 32'h5A5A_0000;
        mreq      = 3'b111;
        sb.push_back('{0, 32'h5A5A_1000, 1'b0, cyc + 1});
        sb.push_back('{1, 32'h5A5A_2000, 1'b0, cyc + 3});
        sb.push_back('{2, 32'h5A5A_3000, 1'b0, cyc + 5});
        g_exp2 = '{2'd3, 2'd0, 2'd3, 2'd1, 2'd3, 2'd2, 2'd3};
        fh_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            half();
            chk($sformatf("t2_grant_%0d", i), 64'(grant), 64'(g_exp2[i]));
            chk($sformatf("t2_fetch_hold_%0d", i), 64'(fetch_hold), 64'(fh_exp[i]));
            if (i == 3) begin
                chk("t2_s_we", 64'(s_we), 64'd1);
                chk("t2_s_wdata", 64'(s_wdata), 64'h1111_2222);
            end
            adv();
        end

        // m1 on a 5-wait slave, m0 arrives mid-transaction
        slv_wait = 5;
        maddr[1] = 32'h0000_4000;
        mwe[1]   = 1'b0;
        mreq[1]  = 1'b1;
        sb.push_back('{1, 32'h5A5A_4000, 1'b0, cyc + 6});
        g_exp3 = '{2'd3, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd0, 2'd3};
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                maddr[0] = 32'h0000_5000;
                mwe[0]   = 1'b0;
                mreq[0]  = 1'b1;
                sb.push_back('{0, 32'h5A5A_5000, 1'b0, cyc + 5});
            end
            if (i == 7) slv_wait = 0;
            half();
            chk($sformatf("t3_grant_%0d", i), 64'(grant), 64'(g_exp3[i]));
            adv();
        end

        // Slave never acks an m1 write: timeout with error, then stray acks
        slv_en    = 1'b0;
        maddr[1]  = 32'h0000_6000;
        mwe[1]    = 1'b1;
        mwdata[1] = 32'hCAFE_F00D;
        mreq[1]   = 1'b1;
        sb.push_back('{1, 32'h0, 1'b1, cyc + TO});
        for (int i = 0; i <= TO; i++) begin
            half();
            if (i == 1) begin
                chk("t4_s_we", 64'(s_we), 64'd1);
                chk("t4_s_wdata", 64'(s_wdata), 64'hCAFE_F00D);
            end
            if (i == TO) chk("t4_timeout_ack", 64'({mack, merr}), 64'b010_010);
            adv();
        end
        stray = 1'b1;
        for (int i = 0; i < 2; i++) begin
            half();
            chk("t4_stray_acks", 64'(mack), 64'd0);
            chk("t4_stray_grant", 64'(grant), 64'd3);
            adv();
        end
        stray = 1'b0;

        // Slave ack lands exactly on the last timeout cycle: ack wins
        slv_en   = 1'b1;
        slv_wait = TO - 1;
        slv_key  = 32'h0F0F_F0F0;
        maddr[0] = 32'h0000_7000;
        mwe[0]   = 1'b0;
        mreq[0]  = 1'b1;
        sb.push_back('{0, 32'h0F0F_F0F0 ^ 32'h0000_7000, 1'b0, cyc + TO});
        for (int i = 0; i <= TO + 1; i++) begin
            half();
            if (i == TO) begin
                chk("t5_ack", 64'(mack), 64'b001);
                chk("t5_err", 64'(merr), 64'd0);
            end
            adv();
        end

        // Reset pulsed in BUSY cycle 2 of a 5-wait access
        slv_wait = 5;
        maddr[1] = 32'h0000_8000;
        mwe[1]   = 1'b0;
        mreq[1]  = 1'b1;
        half();
        adv();
        half();
        chk("t6_busy_s_req", 64'(s_req), 64'd1);
        adv();
        rst = 1'b1;
        half();
        chk("t6_rst_cycle_acks", 64'({mack, merr}), 64'd0);
        adv();
        rst     = 1'b0;
        mreq[1] = 1'b0;
        half();
        chk("t6_after_grant", 64'(grant), 64'd3);
        chk("t6_after_s_req", 64'(s_req), 64'd0);
        chk("t6_after_acks", 64'(mack), 64'd0);
        adv();
        repeat (3) begin
            half();
            chk("t6_quiet_acks", 64'(mack), 64'd0);
            adv();
        end

        // Granted master drops its request before the slave answers
        maddr[0] = 32'h0000_9000;
        mreq[0]  = 1'b1;
        half();
        adv();
        half();
        chk("t7_busy_s_req", 64'(s_req), 64'd1);
        adv();
        mreq[0] = 1'b0;
        half();
        chk("t7_drop_s_req", 64'(s_req), 64'd0);
        chk("t7_drop_acks", 64'(mack), 64'd0);
        adv();
        half();
        chk("t7_after_grant", 64'(grant), 64'd3);
        adv();
        repeat (2) begin
            half();
            adv();
        end

        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
